key_search_sequencer: RTL and testbench

Sequential controller that drives the S-memory port select and the phase start strobes for the RC4 datapath. It runs the phase FSMs (init, shuffle A, shuffle B, decrypt) in order and generates the 3-bit `mem_sel` consumed by the memory-port multiplexer. On each decrypt failure it steps a brute-force key counter and re-runs the sequence. It sits between top-level control and the four phase FSMs.

---
 rtl/key_search_sequencer_if.sv | 33 +++
 rtl/key_search_sequencer.sv | 169 ++++++++++++++++
 tb/tb_key_search_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_search_sequencer_if.sv
// rtl/key_search_sequencer_if.sv - Control/handshake bundle between top-level control, phase FSMs and the key-search sequencer.
interface key_search_sequencer_if #(
  parameter int KEY_WIDTH = 22
);
  logic                 start;
  logic                 init_done;
  logic                 shuffleA_done;
  logic                 shuffleB_done;
  logic                 decrypt_done;
  logic                 decrypt_ok;
  logic [2:0]           mem_sel;
  logic                 init_start;
  logic                 shuffleA_start;
  logic                 shuffleB_start;
  logic                 decrypt_start;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic                 timeout;

  modport master (
    output start, init_done, shuffleA_done, shuffleB_done, decrypt_done, decrypt_ok,
    input  mem_sel, init_start, shuffleA_start, shuffleB_start, decrypt_start,
    input  key, busy, done, found, timeout
  );

  modport slave (
    input  start, init_done, shuffleA_done, shuffleB_done, decrypt_done, decrypt_ok,
    output mem_sel, init_start, shuffleA_start, shuffleB_start, decrypt_start,
    output key, busy, done, found, timeout
  );
endinterface

// File: rtl/key_search_sequencer.sv
// rtl/key_search_sequencer.sv - RC4 brute-force key-search sequencer: phase strobes, mem_sel and key counter.
// Optional per-phase watchdog is built when PHASE_TIMEOUT_EN is defined.
module key_search_sequencer #(
  parameter int KEY_WIDTH      = 22,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   reset_n,
  key_search_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_S,
    INIT_W,
    SHA_S,
    SHA_W,
    SHB_S,
    SHB_W,
    DEC_S,
    DEC_W,
    DONE
  } state_t;

  state_t               state, state_nx;
  logic [KEY_WIDTH-1:0] key_q, key_nx;
  logic                 found_q, found_nx;
  logic [2:0]           mem_sel_q, mem_sel_nx;
  logic [3:0]           strobe_q, strobe_nx;
  logic                 busy_q, done_q;
  logic                 expire;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  always_comb begin
    state_nx = state;
    key_nx   = key_q;
    found_nx = found_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx = INIT_S;
          key_nx   = '0;
          found_nx = 1'b0;
        end
      end
      INIT_S: state_nx = INIT_W;
      INIT_W: if (bus.init_done) state_nx = SHA_S;
      SHA_S:  state_nx = SHA_W;
      SHA_W:  if (bus.shuffleA_done) state_nx = SHB_S;
      SHB_S:  state_nx = SHB_W;
      SHB_W:  if (bus.shuffleB_done) state_nx = DEC_S;
      DEC_S:  state_nx = DEC_W;
      DEC_W: begin
        if (bus.decrypt_done) begin
          if (bus.decrypt_ok) begin
            state_nx = DONE;
            found_nx = 1'b1;
          end else if (key_q != {KEY_WIDTH{1'b1}}) begin
            // S is rebuilt from scratch for every candidate key
            key_nx   = key_q + KEY_WIDTH'(1);
            state_nx = INIT_S;
          end else begin
            state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (expire) begin
      state_nx = DONE;
      found_nx = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it
  always_comb begin
    mem_sel_nx = 3'd0;
    case (state_nx)
      INIT_W:  mem_sel_nx = 3'd1;
      SHA_S:   mem_sel_nx = 3'd2;
      SHA_W:   mem_sel_nx = 3'd3;
      SHB_S:   mem_sel_nx = 3'd4;
      SHB_W:   mem_sel_nx = 3'd5;
      DEC_S:   mem_sel_nx = 3'd6;
      DEC_W:   mem_sel_nx = 3'd7;
      default: mem_sel_nx = 3'd0;
    endcase
    strobe_nx = {state_nx == DEC_S, state_nx == SHB_S, state_nx == SHA_S, state_nx == INIT_S};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_q     <= '0;
      found_q   <= 1'b0;
      mem_sel_q <= 3'd0;
      strobe_q  <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      key_q     <= key_nx;
      found_q   <= found_nx;
      mem_sel_q <= mem_sel_nx;
      strobe_q  <= strobe_nx;
      busy_q    <= (state_nx != IDLE) && (state_nx != DONE);
      done_q    <= (state_nx == DONE);
    end
  end

`ifdef PHASE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             in_wait;
  logic             phase_done;
  logic             launch;

  always_comb begin
    in_wait    = 1'b0;
    phase_done = 1'b0;
    case (state)
      INIT_W: begin in_wait = 1'b1; phase_done = bus.init_done;     end
      SHA_W:  begin in_wait = 1'b1; phase_done = bus.shuffleA_done; end
      SHB_W:  begin in_wait = 1'b1; phase_done = bus.shuffleB_done; end
      DEC_W:  begin in_wait = 1'b1; phase_done = bus.decrypt_done;  end
      default: ;
    endcase
  end

  // A done pulse on the last allowed cycle still wins over the watchdog
  assign expire = in_wait && !phase_done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign launch = ((state == IDLE) || (state == DONE)) && bus.start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= in_wait ? wait_cnt + CNT_W'(1) : '0;
      if (launch) begin
        timeout_q <= 1'b0;
      end else if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.mem_sel        = mem_sel_q;
  assign bus.init_start     = strobe_q[0];
  assign bus.shuffleA_start = strobe_q[1];
  assign bus.shuffleB_start = strobe_q[2];
  assign bus.decrypt_start  = strobe_q[3];
  assign bus.key            = key_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.found          = found_q;

endmodule

// File: tb/tb_key_search_sequencer.sv
// tb/tb_key_search_sequencer.sv - Self-checking bench for key_search_sequencer with a phase/key behavioural model.
`timescale 1ns/1ps
module tb_key_search_sequencer;
  localparam int KW   = 4;
  localparam int TC   = 16;
  localparam int KMAX = (1 << KW) - 1;
`ifdef PHASE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_search_sequencer_if #(.KEY_WIDTH(KW)) bus ();
  key_search_sequencer #(.KEY_WIDTH(KW), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic       start_r = 1'b0;
  logic [3:0] man_pulse = 4'b0;
  logic [3:0] resp_pulse = 4'b0;
  logic       ok_r = 1'b0;
  logic [3:0] resp_en = 4'hF;
  int         resp_delay = 3;
  int         pass_key = 0;
  logic       cap_en = 1'b0;
  logic [2:0] seq[$];
  int         init_total = 0;

  assign bus.start         = start_r;
  assign bus.init_done     = resp_pulse[0] | man_pulse[0];
  assign bus.shuffleA_done = resp_pulse[1] | man_pulse[1];
  assign bus.shuffleB_done = resp_pulse[2] | man_pulse[2];
  assign bus.decrypt_done  = resp_pulse[3] | man_pulse[3];
  assign bus.decrypt_ok    = ok_r;

  // Behavioural model: search active, current phase 0..3, start-cycle vs wait-cycle
  bit m_busy, m_wait, m_done, m_found, m_to;
  int m_phase, m_key, m_wcnt;
  logic [3:0] dn;
  assign dn = {bus.decrypt_done, bus.shuffleB_done, bus.shuffleA_done, bus.init_done};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_wait = 0; m_done = 0; m_found = 0; m_to = 0;
      m_phase = 0; m_key = 0; m_wcnt = 0;
    end else if (!m_busy) begin
      if (start_r) begin
        m_busy = 1; m_wait = 0; m_phase = 0; m_key = 0;
        m_done = 0; m_found = 0; m_to = 0;
      end
    end else if (!m_wait) begin
      m_wait = 1; m_wcnt = 0;
    end else if (dn[m_phase]) begin
      if (m_phase < 3) begin
        m_phase = m_phase + 1; m_wait = 0;
      end else if (bus.decrypt_ok) begin
        m_busy = 0; m_done = 1; m_found = 1;
      end else if (m_key < KMAX) begin
        m_key = m_key + 1; m_phase = 0; m_wait = 0;
      end else begin
        m_busy = 0; m_done = 1;
      end
    end else if (TO_EN && m_wcnt == TC - 1) begin
      m_busy = 0; m_done = 1; m_to = 1;
    end else begin
      m_wcnt = m_wcnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0] e_sel;
    logic [3:0] e_stb, a_stb;
    if (reset_n) begin
      e_sel = m_busy ? 3'(2 * m_phase + int'(m_wait)) : 3'd0;
      e_stb = (m_busy && !m_wait) ? 4'(1 << m_phase) : 4'd0;
      a_stb = {bus.decrypt_start, bus.shuffleB_start, bus.shuffleA_start, bus.init_start};
      checks++;
      if (bus.mem_sel !== e_sel || a_stb !== e_stb || bus.key !== KW'(m_key) ||
          bus.busy !== m_busy || bus.done !== m_done || bus.found !== m_found || bus.timeout !== m_to) begin
        failures++;
        $display("FAIL model_compare t=%0t mem_sel=%0d exp=%0d strobes=%b exp=%b key=%0d exp=%0d bdft=%b%b%b%b exp=%b%b%b%b",
                 $time, bus.mem_sel, e_sel, a_stb, e_stb, bus.key, m_key,
                 bus.busy, bus.done, bus.found, bus.timeout, m_busy, m_done, m_found, m_to);
      end
    end
  end

  always @(negedge clk) if (reset_n && bus.init_start) init_total++;
  always @(negedge clk) if (cap_en && bus.busy) seq.push_back(bus.mem_sel);

  // Phase responder: answers each strobe resp_delay cycles later unless disabled
  int r_cnt = 0;
  int r_ph = 0;
  always @(negedge clk) begin
    resp_pulse = 4'b0;
    if (!reset_n) begin
      r_cnt = 0;
    end else if (bus.init_start | bus.shuffleA_start | bus.shuffleB_start | bus.decrypt_start) begin
      r_ph  = bus.init_start ? 0 : bus.shuffleA_start ? 1 : bus.shuffleB_start ? 2 : 3;
      r_cnt = resp_delay;
    end else if (r_cnt > 0) begin
      r_cnt--;
      if (r_cnt == 0 && resp_en[r_ph]) begin
        resp_pulse[r_ph] = 1'b1;
        ok_r = (m_key >= pass_key);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.done) begin
      failures++;
      $display("FAIL %s_wait got=done0 expected=done1 within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int exp_seq[16] = '{0, 1, 1, 1, 2, 3, 3, 3, 4, 5, 5, 5, 6, 7, 7, 7};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset then idle
    base = init_total;
    repeat (20) @(negedge clk);
    check("idle_init_starts", init_total - base, 0);
    check("idle_mem_sel", bus.mem_sel, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);

    // Happy path on key 0
    base = init_total;
    cap_en = 1'b1;
    pulse_start();
    wait_done("happy", 200);
    cap_en = 1'b0;
    check("happy_seq_len", seq.size(), 16);
    for (int i = 0; i < 16 && i < seq.size(); i++) check($sformatf("happy_seq_%0d", i), seq[i], exp_seq[i]);
    check("happy_found", bus.found, 1);
    check("happy_key", bus.key, 0);
    check("happy_init_starts", init_total - base, 1);

    // Keys 0..4 fail, key 5 passes
    pass_key = 5;
    base = init_total;
    pulse_start();
    wait_done("search", 1000);
    check("search_init_starts", init_total - base, 6);
    check("search_found", bus.found, 1);
    check("search_key", bus.key, 5);

    // Exhaustion: every key fails, key saturates at all-ones
    pass_key = 1000;
    base = init_total;
    pulse_start();
    wait_done("exhaust", 2000);
    check("exhaust_init_starts", init_total - base, 16);
    check("exhaust_found", bus.found, 0);
    check("exhaust_key", bus.key, 15);
    repeat (5) @(negedge clk);
    check("exhaust_key_hold", bus.key, 15);
    check("exhaust_done_hold", bus.done, 1);

    // Spurious handshakes with the responder muted
    resp_en = 4'h0;
    pulse_start();
    @(negedge clk);
    man_pulse = 4'b1000;
    @(negedge clk);
    man_pulse = 4'b0000;
    check("spur_dec_in_init_w", bus.mem_sel, 1);
    man_pulse = 4'b0001;
    @(negedge clk);
    check("spur_enter_sha_s", bus.mem_sel, 2);
    man_pulse = 4'b0001;
    @(negedge clk);
    man_pulse = 4'b0000;
    check("spur_init_in_sha_s", bus.mem_sel, 3);
    @(negedge clk);
    check("spur_sha_w_hold", bus.mem_sel, 3);
    man_pulse = 4'b0010;
    @(negedge clk);
    man_pulse = 4'b0000;
    @(negedge clk);
    check("spur_shb_w", bus.mem_sel, 5);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mem_sel", bus.mem_sel, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_strobes", {bus.init_start, bus.shuffleA_start, bus.shuffleB_start, bus.decrypt_start}, 0);
    check("rst_done_found", {bus.done, bus.found, bus.timeout}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = init_total;
    repeat (10) @(negedge clk);
    check("post_rst_no_strobe", init_total - base, 0);
    check("post_rst_busy", bus.busy, 0);

    // Withhold shuffleA_done
    resp_en = 4'b1101;
    pass_key = 0;
    pulse_start();
    n = 0;
    while (bus.mem_sel != 3'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_reach_sha_w", bus.mem_sel, 3);
    n = 0;
`ifdef PHASE_TIMEOUT_EN
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, 16);
    check("to_timeout", bus.timeout, 1);
    check("to_found", bus.found, 0);
    resp_en = 4'hF;
    pulse_start();
    wait_done("to_rerun", 200);
    check("to_rerun_timeout", bus.timeout, 0);
    check("to_rerun_found", bus.found, 1);
`else
    repeat (40) @(negedge clk);
    check("nto_mem_sel", bus.mem_sel, 3);
    check("nto_busy", bus.busy, 1);
    check("nto_done", bus.done, 0);
    check("nto_timeout", bus.timeout, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
